led_blink_ctrl: RTL and testbench

- Programmable blink-pattern generator that produces the slow LED drive signal.
- Sits directly upstream of pisca_leds: led_out1 here connects to that block's clk_in1 input.
- Turns the fast system clock into OFF, ON, steady BLINK or BURST (N blinks, then pause) waveforms.
- Exposes a one-cycle tick at every LED edge for other consumers.

---
 rtl/led_blink_ctrl.sv | 130 +++++++++++++
 tb/tb_led_blink_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/led_blink_ctrl.sv
// Blink-pattern generator: divides clk_in1 into OFF / ON / BLINK / BURST LED waveforms.
// led_out1 and tick_out are registered; tick_out marks every pattern-driven LED edge.
module led_blink_ctrl #(
  parameter int CNT_W        = 24,
  parameter int DEF_HALF     = 4,
  parameter int PAUSE_HALVES = 2
) (
  input  logic             clk_in1,
  input  logic             rst_n_in1,
  input  logic             cfg_load_in,
  input  logic [1:0]       mode_in,
  input  logic [CNT_W-1:0] half_period_in,
  input  logic [3:0]       burst_len_in,
  output logic             led_out1,
  output logic             tick_out
);

  localparam int PW = (PAUSE_HALVES > 1) ? $clog2(PAUSE_HALVES) : 1;

  typedef enum logic [2:0] {
    S_OFF, S_ON, S_BL_HI, S_BL_LO, S_BU_HI, S_BU_LO, S_PAUSE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [3:0]       burst_q, burst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       blink_cnt_q, blink_cnt_d;
  logic [PW-1:0]    pause_cnt_q, pause_cnt_d;
  logic             led_q, led_d;
  logic             tick_q, tick_d;

  logic             counting;
  logic             half_end;
  logic             burst_more;

  assign counting   = (state_q != S_OFF) && (state_q != S_ON);
  assign half_end   = counting && (cnt_q == half_q - CNT_W'(1));
  assign burst_more = ({1'b0, blink_cnt_q} + 5'd1) < {1'b0, burst_q};

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    half_d      = half_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    blink_cnt_d = blink_cnt_q;
    pause_cnt_d = pause_cnt_q;
    led_d       = led_q;
    tick_d      = 1'b0;

    if (cfg_load_in) begin
      // A load restarts the pattern and swallows any half-end due this cycle.
      mode_d      = mode_in;
      half_d      = (half_period_in == '0) ? CNT_W'(1) : half_period_in;
      burst_d     = (burst_len_in == 4'd0) ? 4'd1 : burst_len_in;
      cnt_d       = '0;
      blink_cnt_d = 4'd0;
      pause_cnt_d = '0;
      unique case (mode_in)
        2'b00: begin state_d = S_OFF;   led_d = 1'b0; end
        2'b01: begin state_d = S_ON;    led_d = 1'b1; end
        2'b10: begin state_d = S_BL_HI; led_d = 1'b1; end
        default: begin state_d = S_BU_HI; led_d = 1'b1; end
      endcase
    end else begin
      cnt_d = counting ? (half_end ? '0 : cnt_q + CNT_W'(1)) : '0;
      if (half_end) begin
        unique case (state_q)
          S_BL_HI: begin state_d = S_BL_LO; led_d = 1'b0; tick_d = 1'b1; end
          S_BL_LO: begin state_d = S_BL_HI; led_d = 1'b1; tick_d = 1'b1; end
          S_BU_HI: begin state_d = S_BU_LO; led_d = 1'b0; tick_d = 1'b1; end
          S_BU_LO: begin
            if (burst_more) begin
              blink_cnt_d = blink_cnt_q + 4'd1;
              state_d     = S_BU_HI;
              led_d       = 1'b1;
              tick_d      = 1'b1;
            end else begin
              // Last LO half rolls straight into the pause; LED already low.
              blink_cnt_d = 4'd0;
              pause_cnt_d = '0;
              state_d     = S_PAUSE;
            end
          end
          S_PAUSE: begin
            if (pause_cnt_q == PW'(PAUSE_HALVES - 1)) begin
              pause_cnt_d = '0;
              state_d     = S_BU_HI;
              led_d       = 1'b1;
              tick_d      = 1'b1;
            end else begin
              pause_cnt_d = pause_cnt_q + PW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in1 or negedge rst_n_in1) begin
    if (!rst_n_in1) begin
      state_q     <= S_OFF;
      mode_q      <= 2'b00;
      half_q      <= CNT_W'(DEF_HALF);
      burst_q     <= 4'd1;
      cnt_q       <= '0;
      blink_cnt_q <= 4'd0;
      pause_cnt_q <= '0;
      led_q       <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      half_q      <= half_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      blink_cnt_q <= blink_cnt_d;
      pause_cnt_q <= pause_cnt_d;
      led_q       <= led_d;
      tick_q      <= tick_d;
    end
  end

  assign led_out1 = led_q;
  assign tick_out = tick_q;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl: expected waveforms are hand-derived per edge index.
module tb_led_blink_ctrl;

  logic        clk_in1 = 1'b0;
  logic        rst_n_in1;
  logic        cfg_load_in;
  logic [1:0]  mode_in;
  logic [23:0] half_period_in;
  logic [3:0]  burst_len_in;
  logic        led_out1;
  logic        tick_out;

  int n_chk  = 0;
  int n_fail = 0;

  led_blink_ctrl #(.CNT_W(24), .DEF_HALF(4), .PAUSE_HALVES(2)) dut (
    .clk_in1       (clk_in1),
    .rst_n_in1     (rst_n_in1),
    .cfg_load_in   (cfg_load_in),
    .mode_in       (mode_in),
    .half_period_in(half_period_in),
    .burst_len_in  (burst_len_in),
    .led_out1      (led_out1),
    .tick_out      (tick_out)
  );

  always #5 clk_in1 = ~clk_in1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in1);
    #1;
  endtask

  // Load pulse spanning exactly one edge ("edge 0"); returns #1 after that edge.
  task automatic load(input logic [1:0] m, input logic [23:0] h, input logic [3:0] b);
    cfg_load_in    = 1'b1;
    mode_in        = m;
    half_period_in = h;
    burst_len_in   = b;
    step();
    cfg_load_in = 1'b0;
  endtask

  logic [15:0] bu_led;
  logic [15:0] bu_tick;

  initial begin
    rst_n_in1      = 1'b0;
    cfg_load_in    = 1'b0;
    mode_in        = 2'b00;
    half_period_in = '0;
    burst_len_in   = '0;

    // Reset held: outputs low.
    repeat (2) begin
      step();
      check("rst_led", led_out1, 0);
      check("rst_tick", tick_out, 0);
    end
    rst_n_in1 = 1'b1;
    repeat (6) begin
      step();
      check("idle_led", led_out1, 0);
      check("idle_tick", tick_out, 0);
    end

    // BLINK half=3: high edges 0-2, low 3-5; tick on multiples of 3.
    load(2'b10, 24'd3, 4'd0);
    // Inputs between loads must be ignored.
    mode_in        = 2'b01;
    half_period_in = 24'd7;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) step();
      check($sformatf("bl3_led_e%0d", k), led_out1, ((k / 3) % 2) == 0);
      check($sformatf("bl3_tick_e%0d", k), tick_out, (k > 0) && (k % 3 == 0));
    end

    // BURST half=2 len=3: 11 00 11 00 11 000000, period 16.
    bu_led  = 16'b1100110011000000;
    bu_tick = 16'b1010101010100000;
    load(2'b11, 24'd2, 4'd3);
    for (int k = 0; k <= 33; k++) begin
      if (k > 0) step();
      check($sformatf("bu_led_e%0d", k), led_out1, bu_led[15 - (k % 16)]);
      check($sformatf("bu_tick_e%0d", k), tick_out, (k > 0) && bu_tick[15 - (k % 16)]);
    end

    // BLINK half=0 behaves as half=1: toggle every edge, tick stuck high.
    load(2'b10, 24'd0, 4'd0);
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) step();
      check($sformatf("bl0_led_e%0d", k), led_out1, (k % 2) == 0);
      check($sformatf("bl0_tick_e%0d", k), tick_out, k > 0);
    end

    // Reload ON mid-BLINK (cnt=1): led 1, no tick, stays steady.
    load(2'b10, 24'd4, 4'd0);
    step();
    load(2'b01, 24'd4, 4'd0);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) step();
      check($sformatf("on_led_e%0d", k), led_out1, 1);
      check($sformatf("on_tick_e%0d", k), tick_out, 0);
    end

    // OFF load drives led low.
    load(2'b00, 24'd4, 4'd0);
    check("off_led", led_out1, 0);
    check("off_tick", tick_out, 0);

    // Async reset mid-BURST at edge 4 (led=1, tick=1), between edges.
    load(2'b11, 24'd2, 4'd3);
    repeat (4) step();
    check("pre_rst_led", led_out1, 1);
    check("pre_rst_tick", tick_out, 1);
    #2 rst_n_in1 = 1'b0;
    #1;
    check("async_rst_led", led_out1, 0);
    check("async_rst_tick", tick_out, 0);
    step();
    rst_n_in1 = 1'b1;
    repeat (10) begin
      step();
      check("post_rst_led", led_out1, 0);
      check("post_rst_tick", tick_out, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
